prim_cmd_fetch: RTL

//  Command fetcher sitting directly downstream of the 9-read-port command RAM.

---
 rtl/prim_cmd_fetch_pkg.sv | 31 +++
 rtl/prim_cmd_fetch_if.sv | 29 ++
 rtl/prim_cmd_decode.sv | 69 ++++++
 rtl/prim_cmd_fetch.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/prim_cmd_fetch_pkg.sv
// prim_cmd_fetch_pkg
//   Shared definitions for the command fetcher. It holds the record opcodes,
//   the record length, the decoded operation codes seen by the rasterizer and
//   the fetcher FSM states.
//   Ports: none (package).
package prim_cmd_fetch_pkg;

  // Opcode values found in word 0 of a record
  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_LINE = 8'h01;
  localparam logic [7:0] OPC_TRI  = 8'h02;
  localparam logic [7:0] OPC_END  = 8'hFF;

  // Words per record: w0 opcode, w1..w6 coordinates, w7 colour, w8 reserved
  localparam int unsigned CMD_WORDS = 9;

  // Operation code presented to the rasterizer on cmd_op
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_LINE = 2'd1,
    CMD_TRI  = 2'd2
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DONE
  } fetch_state_t;

endpackage

// File: rtl/prim_cmd_fetch_if.sv
// prim_cmd_fetch_if
//   Valid/ready record channel from the command fetcher to the rasterizer.
//   master: drives cmd_valid, cmd_op, cmd_x0..cmd_y2, cmd_color; samples cmd_ready
//   slave : samples the record fields; drives cmd_ready
interface prim_cmd_fetch_if #(
  parameter int unsigned COORD_WIDTH = 10,
  parameter int unsigned COLOR_WIDTH = 24
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [COORD_WIDTH-1:0] cmd_x0;
  logic [COORD_WIDTH-1:0] cmd_y0;
  logic [COORD_WIDTH-1:0] cmd_x1;
  logic [COORD_WIDTH-1:0] cmd_y1;
  logic [COORD_WIDTH-1:0] cmd_x2;
  logic [COORD_WIDTH-1:0] cmd_y2;
  logic [COLOR_WIDTH-1:0] cmd_color;

  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/prim_cmd_decode.sv
// prim_cmd_decode
//   Combinational decode of one primitive record.
//   w0..w7        in   record words (w8 is reserved and not needed here)
//   op            out  CMD_LINE / CMD_TRI for drawable records, else CMD_NONE
//   is_cmd        out  record is LINE or TRI
//   is_end        out  record terminates the list
//   is_bad        out  opcode is not one of NOP/LINE/TRI/END
//   x0..y2, color out  low bits of w1..w7; x2/y2 forced to 0 unless TRI
module prim_cmd_decode
  import prim_cmd_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COORD_WIDTH = 10,
  parameter int unsigned COLOR_WIDTH = 24
) (
  input  logic [DATA_WIDTH-1:0]  w0,
  input  logic [DATA_WIDTH-1:0]  w1,
  input  logic [DATA_WIDTH-1:0]  w2,
  input  logic [DATA_WIDTH-1:0]  w3,
  input  logic [DATA_WIDTH-1:0]  w4,
  input  logic [DATA_WIDTH-1:0]  w5,
  input  logic [DATA_WIDTH-1:0]  w6,
  input  logic [DATA_WIDTH-1:0]  w7,
  output cmd_op_t                op,
  output logic                   is_cmd,
  output logic                   is_end,
  output logic                   is_bad,
  output logic [COORD_WIDTH-1:0] x0,
  output logic [COORD_WIDTH-1:0] y0,
  output logic [COORD_WIDTH-1:0] x1,
  output logic [COORD_WIDTH-1:0] y1,
  output logic [COORD_WIDTH-1:0] x2,
  output logic [COORD_WIDTH-1:0] y2,
  output logic [COLOR_WIDTH-1:0] color
);
  logic [7:0] opcode;
  logic       unused_bits;

  assign opcode = w0[7:0];

  always_comb begin
    op     = CMD_NONE;
    is_cmd = 1'b0;
    is_end = 1'b0;
    is_bad = 1'b0;
    case (opcode)
      OPC_LINE: begin op = CMD_LINE; is_cmd = 1'b1; end
      OPC_TRI:  begin op = CMD_TRI;  is_cmd = 1'b1; end
      OPC_NOP:  ;
      OPC_END:  is_end = 1'b1;
      default:  is_bad = 1'b1;
    endcase
  end

  // Plain truncation: upper word bits are ignored, never sign-extended
  assign x0    = w1[COORD_WIDTH-1:0];
  assign y0    = w2[COORD_WIDTH-1:0];
  assign x1    = w3[COORD_WIDTH-1:0];
  assign y1    = w4[COORD_WIDTH-1:0];
  assign x2    = (op == CMD_TRI) ? w5[COORD_WIDTH-1:0] : '0;
  assign y2    = (op == CMD_TRI) ? w6[COORD_WIDTH-1:0] : '0;
  assign color = w7[COLOR_WIDTH-1:0];

  assign unused_bits = ^{w0[DATA_WIDTH-1:8],
                         w1[DATA_WIDTH-1:COORD_WIDTH], w2[DATA_WIDTH-1:COORD_WIDTH],
                         w3[DATA_WIDTH-1:COORD_WIDTH], w4[DATA_WIDTH-1:COORD_WIDTH],
                         w5[DATA_WIDTH-1:COORD_WIDTH], w6[DATA_WIDTH-1:COORD_WIDTH],
                         w7[DATA_WIDTH-1:COLOR_WIDTH]};
endmodule

// File: rtl/prim_cmd_fetch.sv
// prim_cmd_fetch
//   Walks a list of 9-word primitive records in the command RAM starting at
//   base_addr, decodes one record per FETCH cycle and presents LINE/TRI records
//   to the rasterizer over a valid/ready channel.
//   clk, rst                in   clock, synchronous active-high reset
//   start                   in   begin a list walk (sampled only in IDLE)
//   base_addr               in   address of the first record
//   cmd_count               in   max records to process; 0 finishes at once
//   read_addr               out  registered RAM read address
//   read_data1..read_data9  in   RAM words at read_addr+0..+8 (async read)
//   cmd                     if   record channel (master side)
//   busy                    out  high outside IDLE
//   done                    out  one-cycle pulse at end of list
//   bad_op                  out  one-cycle pulse after an unknown opcode is skipped
module prim_cmd_fetch
  import prim_cmd_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COORD_WIDTH = 10,
  parameter int unsigned COLOR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            cmd_count,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data1,
  input  logic [DATA_WIDTH-1:0] read_data2,
  input  logic [DATA_WIDTH-1:0] read_data3,
  input  logic [DATA_WIDTH-1:0] read_data4,
  input  logic [DATA_WIDTH-1:0] read_data5,
  input  logic [DATA_WIDTH-1:0] read_data6,
  input  logic [DATA_WIDTH-1:0] read_data7,
  input  logic [DATA_WIDTH-1:0] read_data8,
  input  logic [DATA_WIDTH-1:0] read_data9,
  prim_cmd_fetch_if.master      cmd,
  output logic                  busy,
  output logic                  done,
  output logic                  bad_op
);
  fetch_state_t state, state_next;

  logic [7:0]             remaining;
  logic                   load_base, load_cmd, advance, flag_bad;
  logic                   last_record;
  logic                   unused_rsvd;

  cmd_op_t                dec_op;
  logic                   dec_cmd, dec_end, dec_bad;
  logic [COORD_WIDTH-1:0] dec_x0, dec_y0, dec_x1, dec_y1, dec_x2, dec_y2;
  logic [COLOR_WIDTH-1:0] dec_color;

  logic                   valid_q;
  logic [1:0]             op_q;
  logic [COORD_WIDTH-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
  logic [COLOR_WIDTH-1:0] color_q;

  prim_cmd_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .COORD_WIDTH(COORD_WIDTH),
    .COLOR_WIDTH(COLOR_WIDTH)
  ) u_decode (
    .w0(read_data1), .w1(read_data2), .w2(read_data3), .w3(read_data4),
    .w4(read_data5), .w5(read_data6), .w6(read_data7), .w7(read_data8),
    .op(dec_op), .is_cmd(dec_cmd), .is_end(dec_end), .is_bad(dec_bad),
    .x0(dec_x0), .y0(dec_y0), .x1(dec_x1), .y1(dec_y1), .x2(dec_x2), .y2(dec_y2),
    .color(dec_color)
  );

  // Reserved word is carried by the RAM but has no meaning yet
  assign unused_rsvd = ^read_data9;

  assign last_record = (remaining == 8'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_base  = 1'b0;
    load_cmd   = 1'b0;
    advance    = 1'b0;
    flag_bad   = 1'b0;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_base  = 1'b1;
          state_next = (cmd_count == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (dec_end) begin
          // END terminates without consuming a count or moving the address
          state_next = ST_DONE;
        end else if (dec_cmd) begin
          load_cmd   = 1'b1;
          state_next = ST_ISSUE;
        end else begin
          advance    = 1'b1;
          flag_bad   = dec_bad;
          state_next = last_record ? ST_DONE : ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (valid_q && cmd.cmd_ready) begin
          advance    = 1'b1;
          state_next = last_record ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_addr <= '0;
      remaining <= '0;
      bad_op    <= 1'b0;
      valid_q   <= 1'b0;
      op_q      <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      color_q   <= '0;
    end else begin
      bad_op <= flag_bad;
      if (load_base) begin
        read_addr <= base_addr;
        remaining <= cmd_count;
      end
      if (advance) begin
        read_addr <= read_addr + ADDR_WIDTH'(CMD_WORDS);
        remaining <= remaining - 8'd1;
        valid_q   <= 1'b0;
      end
      if (load_cmd) begin
        valid_q <= 1'b1;
        op_q    <= dec_op;
        x0_q    <= dec_x0;
        y0_q    <= dec_y0;
        x1_q    <= dec_x1;
        y1_q    <= dec_y1;
        x2_q    <= dec_x2;
        y2_q    <= dec_y2;
        color_q <= dec_color;
      end
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_op    = op_q;
  assign cmd.cmd_x0    = x0_q;
  assign cmd.cmd_y0    = y0_q;
  assign cmd.cmd_x1    = x1_q;
  assign cmd.cmd_y1    = y1_q;
  assign cmd.cmd_x2    = x2_q;
  assign cmd.cmd_y2    = y2_q;
  assign cmd.cmd_color = color_q;
endmodule
